// File: rtl/wb_host_master.sv
// Wishbone classic initiator: each accepted command becomes exactly one bus
// cycle and produces exactly one response (read data, or a timeout error).
// One transaction is outstanding at a time.
//
// Handshake rule for both the cmd and rsp channels: a transfer happens on a
// rising edge where valid && ready are both high. The producer holds valid and
// its payload stable until that edge, and ready never depends on valid within
// the same cycle.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last counter value before abort: stb stays high for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // Next-state and registered-output logic for the IDLE/BUS/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cnt_d   = '0;
        end
      end
      S_BUS: begin
        // Ack is tested first so an ack on the timeout edge completes normally.
        if (wbm_ack_i) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'h0;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the state they describe.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: a behavioural Wishbone slave with per-command
// wait states, a response scoreboard and randomized command traffic.
module tb_wb_host_master;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;
  logic [7:0]  err_count;

  wb_host_master #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy),
    .err_count (err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;

  // Expected response: {err_count, rsp_err, rsp_dat}
  logic [40:0]  exp_q[$];
  // Slave-side expectations per command
  int           sl_wait_q[$];
  logic [31:0]  sl_rdat_q[$];
  logic [68:0]  sl_cmd_q[$];   // {we, sel, adr, dat}

  int ec_model = 0;            // timeouts seen since reset, saturating at 255
  int hold_ready = 0;
  int stray_ack = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // ---------------- driver tasks ----------------
  // Reference model: the slave acks in stb cycle waits+1; the transaction
  // succeeds only if that happens within TIMEOUT stb cycles.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int waits);
    logic [31:0] rdat;
    logic [31:0] edat;
    logic        eerr;
    int          guard;
    rdat = $urandom;
    if (waits < TIMEOUT) begin
      eerr = 1'b0;
      edat = we ? 32'h0 : rdat;
    end else begin
      eerr = 1'b1;
      edat = 32'h0;
      if (ec_model < 255) ec_model++;
    end
    guard = 0;
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      note_fail("cmd_ready_wait");
      return;
    end
    exp_q.push_back({8'(ec_model), eerr, edat});
    sl_wait_q.push_back(waits);
    sl_rdat_q.push_back(rdat);
    sl_cmd_q.push_back({we, sel, adr, dat});
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = $urandom_range(0, 1);
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) note_fail("drain");
  endtask

  // ---------------- behavioural slave ----------------
  initial begin
    int          scnt;
    int          cur_wait;
    int          cur_len;
    logic [31:0] cur_rdat;
    logic [68:0] cur_cmd;
    scnt = 0; cur_wait = 0; cur_len = 0; cur_rdat = '0; cur_cmd = '0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom;
      if (wb_rst_i) begin
        scnt = 0;
      end else if (wbm_stb_o) begin
        if (scnt == 0) begin
          if (sl_wait_q.size() == 0) begin
            note_fail("unexpected_bus_cycle");
            cur_wait = 0; cur_len = 1; cur_rdat = '0; cur_cmd = '0;
          end else begin
            cur_wait = sl_wait_q.pop_front();
            cur_rdat = sl_rdat_q.pop_front();
            cur_cmd  = sl_cmd_q.pop_front();
            cur_len  = (cur_wait < TIMEOUT) ? cur_wait + 1 : TIMEOUT;
          end
        end
        check("bus_signals", {wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
              {1'b1, cur_cmd});
        if (scnt == cur_wait) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = cur_rdat;
        end
        scnt++;
      end else begin
        if (scnt > 0) check("stb_length", scnt, cur_len);
        scnt = 0;
      end
      if (stray_ack != 0) wbm_ack_i = 1'b1;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [40:0] e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_rst_i || hold_ready != 0) rsp_ready = 1'b0;
      else rsp_ready = ($urandom_range(0, 3) != 0);
      // Handshake happens on the coming rising edge.
      if (!wb_rst_i && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_dat", rsp_dat, e[31:0]);
          check("rsp_err", rsp_err, e[32]);
          check("err_count", err_count, e[40:33]);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [40:0] e;
    int g;
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_dat}, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    wb_rst_i = 1'b0;
    @(negedge clk);

    // Zero-wait read
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0);
    drain();
    // Write with 3 wait states
    issue(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, 3);
    drain();
    // Timeout with no ack
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1000);
    drain();
    check("err_count_after_timeout", err_count, 1);
    // Ack in the last allowed stb cycle, and one cycle too late
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF, TIMEOUT - 1);
    issue(1'b0, 32'h3000_0034, 32'h0, 4'hF, TIMEOUT);
    drain();

    // Backpressure: response held for 5 cycles, cmd pulse ignored
    hold_ready = 1;
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0);
    g = 0;
    while (!rsp_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) note_fail("bp_rsp_valid_wait");
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_dat", rsp_dat, e[31:0]);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_busy", busy, 1);
      if (i == 1) begin
        cmd_valid = 1'b1;
        cmd_adr   = 32'hBAD0_0000;
      end
      if (i == 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    hold_ready = 0;
    drain();
    repeat (3) @(negedge clk);
    check("bp_no_extra_cycle", wbm_cyc_o, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 10));
    end
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'hF,
            TIMEOUT + $urandom_range(0, 5));
    end
    drain();
    check("err_count_saturated", err_count, 255);

    // Reset during BUS
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF, 1000);
    @(posedge clk);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    exp_q.delete();
    sl_wait_q.delete();
    sl_rdat_q.delete();
    sl_cmd_q.delete();
    ec_model = 0;
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_adr", wbm_adr_o, 0);

    // Stray ack outside BUS
    stray_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_rsp_valid", rsp_valid, 0);
      check("stray_cmd_ready", cmd_ready, 1);
    end
    stray_ack = 0;
    @(negedge clk);

    // Recovery after reset
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hA, 2);
    issue(1'b1, 32'h3000_0064, 32'hCAFE_F00D, 4'h5, 9);
    drain();
    check("final_err_count", err_count, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
Wishbone classic initiator that turns single-word command requests into one Wishbone bus cycle each. It is the master-side counterpart to the user-area Wishbone slave port, for test harnesses and on-chip bridges (UART/SPI-to-bus) that must drive a slave. Each command produces exactly one response, with data or a timeout error. No pipelining: one outstanding transaction at a time.

Parameters:
TIMEOUT, 255, cycles stb may stay high without ack before the transaction aborts with an error (legal range 1..65535)
CNT_W, 16, width of the timeout counter; must hold TIMEOUT

Ports:
wb_clk_i  input  1  clock; all logic on rising edge
wb_rst_i  input  1  asynchronous active-high reset
cmd_valid  input  1  command request valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clock edge
cmd_we  input  1  1 = write, 0 = read
cmd_adr  input  32  byte address
cmd_dat  input  32  write data
cmd_sel  input  4  byte lane selects
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a clock edge
rsp_dat  output  32  read data (0 for writes and errors)
rsp_err  output  1  1 = timeout abort
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte selects
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_ack_i  input  1  Wishbone acknowledge
wbm_dat_i  input  32  Wishbone read data
busy  output  1  high in BUS or RESP state
err_count  output  8  saturating count of timeouts since reset

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE; all outputs 0 except cmd_ready=1. This covers cyc, stb, we, sel, adr, dat, rsp_*, busy and err_count. Asserting reset mid-cycle drops cyc/stb immediately, with no response issued.
- States: IDLE, BUS, RESP. All outputs are registered. cmd_ready = (state==IDLE).
- IDLE: on cmd handshake at edge N, latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear the timeout counter, and go to BUS. Bus signals are visible from cycle N+1.
- BUS: wbm_* signals stay stable until the cycle ends.
  - Ack: ack_i sampled high at an edge → cyc=stb=we=0 next cycle. rsp_dat=wbm_dat_i if read, else 0. rsp_err=0, rsp_valid=1, go to RESP.
  - No ack: counter increments each edge. When the counter reaches TIMEOUT-1 without ack → cyc=stb=0, rsp_err=1, rsp_dat=0, rsp_valid=1, err_count+1 (saturates at 255), go to RESP.
  - stb is therefore high for exactly TIMEOUT cycles in the abort case.
  - Ack on the same edge as the timeout: ack wins, no error.
- RESP: rsp_* held stable until rsp_ready. On the handshake, rsp_valid=0 and the block returns to IDLE, so cmd_ready=1 the next cycle. Minimum command-to-command spacing is 3 cycles with a zero-wait slave.
- ack_i outside BUS is ignored and never produces a response.
- wbm_adr_o/dat_o/sel_o hold their last values in IDLE; only cyc/stb qualify them.
- cmd inputs are ignored while cmd_ready=0.

Test Plan:
- Read, zero-wait slave: cmd adr=0x3000_0004 we=0 sel=0xF, slave acks the first stb cycle with 0xDEADBEEF → stb high 1 cycle; rsp_valid 1 cycle after ack; rsp_dat=0xDEADBEEF, rsp_err=0.
- Write with 3 wait states: cmd we=1 dat=0x12345678 sel=0x3 → cyc/stb/we/sel/dat stable for 4 cycles; response rsp_dat=0, rsp_err=0.
- Timeout at TIMEOUT=8, no ack → stb high exactly 8 cycles; response rsp_err=1, rsp_dat=0; err_count=1. Repeat 300 times → err_count saturates at 255.
- Ack on the timeout edge (ack in the 8th stb cycle, TIMEOUT=8) → rsp_err=0 and the data is returned.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_dat stable and cmd_ready=0 throughout; a cmd_valid pulse in this window is not accepted.
- Reset asserted during BUS → cyc/stb=0 asynchronously (before the next edge); after release cmd_ready=1, rsp_valid=0, and a stray ack_i produces no response.
